// File: rtl/envelope_sequencer.sv
// envelope_sequencer: steps the envelope ROM address and scales the sample stream by the returned amplitude.
// Optional fade-out RELEASE state enabled by defining ENVELOPE_RELEASE_EN.
module envelope_sequencer #(
  parameter int STEP_DIV = 1024,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       note_on,
  input  logic                       note_off,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_in_valid,
  input  logic [9:0]                 env_in,
  output logic [5:0]                 duration,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_out_valid,
  output logic                       active
);
  localparam int PW = $clog2(STEP_DIV);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, RELEASE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic tick;
  logic gate_d;
  logic [9:0] env_eff, env_s1;
  logic signed [SAMPLE_W-1:0] samp_s1;
  logic valid_s1;
  logic signed [SAMPLE_W+10:0] prod;
`ifdef ENVELOPE_RELEASE_EN
  logic [3:0] shift, shift_d;
`else
  logic [3:0] shift_d;
  assign shift_d = '0;
`endif
  assign tick = presc == PW'(STEP_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      duration <= '0;
      active   <= 1'b0;
`ifdef ENVELOPE_RELEASE_EN
      shift    <= '0;
`endif
    end else if (note_on) begin
      state    <= RUN;
      presc    <= '0;
      duration <= '0;
      active   <= 1'b1;
`ifdef ENVELOPE_RELEASE_EN
      shift    <= '0;
`endif
    end else if (note_off && (state == RUN || state == HOLD)) begin
`ifdef ENVELOPE_RELEASE_EN
      state    <= RELEASE;
      presc    <= '0;
`else
      state    <= IDLE;
      duration <= '0;
      active   <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (duration == 6'd63) state <= HOLD;
            else duration <= duration + 1'b1;
          end
        end
`ifdef ENVELOPE_RELEASE_EN
        RELEASE: begin
          presc <= tick ? '0 : presc + 1'b1;
          // the tenth step would silence the envelope entirely, so drop to IDLE instead
          if (tick) begin
            if (shift == 4'd9) begin
              state    <= IDLE;
              duration <= '0;
              active   <= 1'b0;
              shift    <= '0;
            end else shift <= shift + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
  // gate and shift are delayed one cycle to line up with the ROM read latency
  assign env_eff = gate_d ? env_in >> shift_d : '0;
  assign prod = samp_s1 * $signed({1'b0, env_s1});
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_d           <= 1'b0;
      samp_s1          <= '0;
      env_s1           <= '0;
      valid_s1         <= 1'b0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
`ifdef ENVELOPE_RELEASE_EN
      shift_d          <= '0;
`endif
    end else begin
      gate_d           <= active;
      samp_s1          <= sample_in;
      env_s1           <= env_eff;
      valid_s1         <= sample_in_valid;
      sample_out       <= SAMPLE_W'(prod >>> 10);
      sample_out_valid <= valid_s1;
`ifdef ENVELOPE_RELEASE_EN
      shift_d          <= shift;
`endif
    end
  end
endmodule

// File: tb/tb_envelope_sequencer.sv
// tb_envelope_sequencer: directed bench with a timeline-based envelope model and a ROM stand-in.
module tb_envelope_sequencer;
  localparam int SD = 4;
  localparam int SW = 16;
  logic clk = 1'b0, reset = 1'b1, note_on = 1'b0, note_off = 1'b0;
  logic sample_in_valid = 1'b0, env_force = 1'b0;
  logic signed [SW-1:0] sample_in = '0;
  logic [9:0] env_in = '0;
  logic [5:0] duration;
  logic signed [SW-1:0] sample_out;
  logic sample_out_valid, active;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  envelope_sequencer #(.STEP_DIV(SD), .SAMPLE_W(SW)) dut (
    .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid), .env_in(env_in),
    .duration(duration), .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .active(active)
  );
  function automatic int rom(input int d);
    return 384 + 10 * d;
  endfunction
  always @(posedge clk) env_in <= env_force ? 10'd1023 : 10'(rom(int'(duration)));
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  function automatic longint floordiv(input longint p);
    longint q = p / 1024;
    if (p < 0 && q * 1024 != p) q--;
    return q;
  endfunction
  typedef enum {M_IDLE, M_NOTE, M_REL} mode_t;
  mode_t mode = M_IDLE;
  int t_on = 0, t_rel = 0, frozen = 0;
  int dur_p = 0, g_p = 0, sh_p = 0, gd_p = 0, shd_p = 0, ein_p = 0, v1_p = 0, ov_p = 0;
  longint s1_p = 0, e1_p = 0, out_p = 0;
  always @(posedge clk) begin : model
    int eff, ein_n, gd_n, shd_n, v1_n, ov_n;
    longint s1_n, e1_n, out_n;
    cyc++;
    eff = gd_p != 0 ? (ein_p >> shd_p) : 0;
    ein_n = env_force ? 1023 : rom(dur_p);
    gd_n = reset ? 0 : g_p;
    shd_n = reset ? 0 : sh_p;
    out_n = reset ? 0 : floordiv(s1_p * e1_p);
    ov_n = reset ? 0 : v1_p;
    s1_n = reset ? 0 : longint'(sample_in);
    e1_n = reset ? 0 : eff;
    v1_n = reset ? 0 : int'(sample_in_valid);
    if (reset) mode = M_IDLE;
    else if (note_on) begin
      mode = M_NOTE;
      t_on = cyc;
    end else if (note_off && mode == M_NOTE) begin
`ifdef ENVELOPE_RELEASE_EN
      mode = M_REL;
      t_rel = cyc;
      frozen = dur_p;
`else
      mode = M_IDLE;
`endif
    end
    if (mode == M_REL && (cyc - t_rel) / SD >= 10) mode = M_IDLE;
    dur_p = mode == M_NOTE ? ((cyc - t_on) / SD > 63 ? 63 : (cyc - t_on) / SD) : mode == M_REL ? frozen : 0;
    g_p = mode != M_IDLE ? 1 : 0;
    sh_p = mode == M_REL ? (cyc - t_rel) / SD : 0;
    gd_p = gd_n;
    shd_p = shd_n;
    ein_p = ein_n;
    out_p = out_n;
    ov_p = ov_n;
    s1_p = s1_n;
    e1_p = e1_n;
    v1_p = v1_n;
    #1;
    chk("duration", duration, dur_p);
    chk("active", active, g_p);
    chk("out_valid", sample_out_valid, ov_p);
    if (ov_p != 0) chk("sample_out", sample_out, out_p);
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  initial begin
    step(2);
    reset = 1'b0;
    chk("rst_duration", duration, 0);
    chk("rst_active", active, 0);
    chk("rst_out", sample_out, 0);
    chk("rst_valid", sample_out_valid, 0);
    sample_in_valid = 1'b1;
    sample_in = 16'sd1000;
    step(6);
    chk("idle_out", sample_out, 0);
    chk("idle_valid", sample_out_valid, 1);
    sample_in = 16'sd16384;
    note_on = 1'b1;
    step();
    note_on = 1'b0;
    chk("on_active", active, 1);
    chk("on_dur", duration, 0);
    step(3);
    chk("first_out", sample_out, 6144);
    chk("dur_k3", duration, 0);
    step();
    chk("dur_k4", duration, 1);
    step(248);
    chk("dur_k252", duration, 63);
    step(8);
    chk("hold_dur", duration, 63);
    env_force = 1'b1;
    sample_in = 16'sd1000;
    step(4);
    chk("hold_pos", sample_out, 999);
    sample_in = -16'sd1000;
    step(4);
    chk("hold_neg_floor", sample_out, -1000);
    sample_in = -16'sd32768;
    step(4);
    chk("hold_min", sample_out, -32736);
    env_force = 1'b0;
    sample_in = 16'sd16384;
    note_on = 1'b1;
    step();
    note_on = 1'b0;
    step(120);
    chk("dur30", duration, 30);
    note_on = 1'b1;
    step();
    note_on = 1'b0;
    chk("restart_dur", duration, 0);
    step(3);
    chk("restart_presc0", duration, 0);
    step();
    chk("restart_presc1", duration, 1);
    note_on = 1'b1;
    note_off = 1'b1;
    step();
    note_on = 1'b0;
    note_off = 1'b0;
    chk("onoff_active", active, 1);
    chk("onoff_dur", duration, 0);
`ifdef ENVELOPE_RELEASE_EN
    step(260);
    env_force = 1'b1;
    sample_in = 16'sd1024;
    step(4);
    chk("rel_pre", sample_out, 1023);
    note_off = 1'b1;
    step();
    note_off = 1'b0;
    chk("rel_active", active, 1);
    chk("rel_dur", duration, 63);
    step(8);
    chk("rel_s1", sample_out, 511);
    step(4);
    chk("rel_s2", sample_out, 255);
    step(27);
    chk("rel_late_active", active, 1);
    step();
    chk("rel_end_active", active, 0);
    chk("rel_end_dur", duration, 0);
    step(3);
    chk("rel_end_out", sample_out, 0);
    note_off = 1'b1;
    step();
    note_off = 1'b0;
    chk("off_in_idle", active, 0);
`else
    step(10);
    note_off = 1'b1;
    step();
    note_off = 1'b0;
    chk("off_active", active, 0);
    chk("off_dur", duration, 0);
    step(3);
    chk("off_out", sample_out, 0);
`endif
    env_force = 1'b0;
    sample_in = 16'sd16384;
    note_on = 1'b1;
    step();
    note_on = 1'b0;
    step(20);
    reset = 1'b1;
    note_on = 1'b1;
    step();
    reset = 1'b0;
    note_on = 1'b0;
    chk("mid_rst_dur", duration, 0);
    chk("mid_rst_out", sample_out, 0);
    chk("mid_rst_valid", sample_out_valid, 0);
    chk("mid_rst_active", active, 0);
    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/envelope_sequencer.md
# envelope_sequencer

Drives the 6-bit `duration` address of the exponential envelope ROM and applies the returned 10-bit amplitude to the oscillator sample stream. It acts as the reader of the envelope table. On a note trigger it steps the address from 0 to 63 at a programmable rate, holds at the tail until note release, and optionally fades out. It sits between the note/oscillator path and the audio output mixer.

## Interface
- `STEP_DIV`, 1024: clock cycles per envelope address step; must be ≥ 2.
- `SAMPLE_W`, 16: signed audio sample width.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `note_on`  in  1  single-cycle pulse; starts or restarts the envelope.
- `note_off`  in  1  single-cycle pulse; ends the note.
- `sample_in`  in  SAMPLE_W  signed oscillator sample.
- `sample_in_valid`  in  1  qualifies `sample_in`.
- `env_in`  in  10  ROM `dout`; valid one cycle after `duration`.
- `duration`  out  6  ROM address, registered.
- `sample_out`  out  SAMPLE_W  signed enveloped sample, registered.
- `sample_out_valid`  out  1  qualifies `sample_out`.
- `active`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, HOLD, RELEASE (RELEASE only with the macro; see Configuration).
- Prescaler `presc` counts 0..STEP_DIV-1 in RUN and RELEASE and wraps. One "step tick" occurs when `presc == STEP_DIV-1`.
- IDLE: `duration` = 0 and gate = 0.
- `note_on` in any state → RUN, with `duration` = 0, `presc` = 0, release shift = 0, gate = 1.
- RUN: on each step tick, `duration` increments. When the tick occurs with `duration == 63`, go to HOLD. `duration` stays 63 and never wraps.
- HOLD: `duration` = 63 and the prescaler is frozen.
- `note_off` in RUN or HOLD ends the note (see Configuration). `note_off` in IDLE or RELEASE is ignored.
- `note_on` and `note_off` in the same cycle: `note_on` wins.
- The ROM has one cycle of read latency. Gate and release shift are each delayed by one register so they align with `env_in`.
- Effective envelope: `env_eff = gate_d ? (env_in >> shift_d) : 0`. This is a 10-bit unsigned value.
- Scaling: `prod = sample_in * {1'b0, env_eff}` (signed, SAMPLE_W+11 bits). `sample_out = prod >>> 10`, an arithmetic shift that floors toward −∞.
- Because `env_eff ≤ 1023`, `|sample_out| ≤ |sample_in|`, so no saturation is needed.
- Samples always pass through. In IDLE, `sample_out` = 0 with valid still asserted.

## Timing
- Reset values: `duration` = 0, `sample_out` = 0, `sample_out_valid` = 0, `active` = 0, state IDLE, prescaler 0, pipeline registers 0.
- `reset` overrides `note_on` in the same cycle and aborts any state.
- `note_on` sampled at edge k: state RUN and `active` = 1 from edge k.
- `duration` = 1 at edge k+STEP_DIV, then 63 at edge k+63·STEP_DIV.
- HOLD is entered at edge k+64·STEP_DIV.
- Sample pipeline has 2 cycles of latency: `sample_in_valid` at edge t → `sample_out_valid` at edge t+2.
- No backpressure. `sample_in_valid` may assert on every cycle.
- The envelope value used is the `env_eff` present at edge t.

## Configuration
- `ENVELOPE_RELEASE_EN` defined: `note_off` → RELEASE with prescaler reset to 0.
  - `duration` is frozen and the release shift increments on each step tick.
  - When the shift reaches 10, go to IDLE (gate 0).
  - `active` stays high throughout RELEASE.
- `ENVELOPE_RELEASE_EN` undefined: `note_off` → IDLE directly, with `active` = 0 at the next edge. RELEASE logic and the shift register are absent, and the shift is held at 0.

## Test plan
- Reset, then `sample_in` = 1000 valid for several cycles with no note → `sample_out` = 0 and valid exactly 2 cycles after each input; `duration` = 0, `active` = 0.
- STEP_DIV = 4, `note_on` at edge 0, `sample_in` = 16384 continuous → `duration` 0 until edge 4, 63 at edge 252, HOLD at edge 256; first nonzero output = 6144 (env 384).
- Force `env_in` = 1023 in HOLD: `sample_in` = 1000 → 999; `sample_in` = −1000 → −1000 (floor); −32768 → −32736.
- `note_on` mid-RUN at `duration` = 30 → `duration` = 0 at the next edge, prescaler restarted. Same-cycle `note_on` + `note_off` → RUN.
- With `ENVELOPE_RELEASE_EN`, STEP_DIV = 4, `env_in` = 1023, `note_off` in HOLD → output for input 1024 steps 1023, 511, 255, … every 4 cycles. IDLE after 40 cycles, output 0, `active` falls.
- Without the macro, `note_off` in RUN → `active` = 0 next edge, output 0 two cycles later. `reset` asserted mid-RUN → all outputs at reset values next edge.
